// File: rtl/counter_ctrl.sv
// counter_ctrl: run/pause/direction controller for the iCEstick LED counter.
// Raw buttons are synchronised and debounced, and a RUN-only prescaler paces the count.

module counter_btn #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] stable_cnt;

  // stable_cnt counts consecutive synchronised samples that disagree with level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_cnt <= '0;
        level      <= sync2;
        press      <= sync2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end
endmodule

module counter_ctrl #(
  parameter int CLK_HZ          = 12000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int WIDTH           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_dir,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             dir,
  output logic             tick,
  output logic             done
);
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NUM_BTN = 3;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;
  logic               start_ev;
  logic               stop_ev;
  logic               dir_ev;

  assign btn_raw  = {btn_dir, btn_stop, btn_start};
  assign start_ev = press[0];
  assign stop_ev  = press[1];
  assign dir_ev   = press[2];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  state_t             state;
  state_t             state_nx;
  logic [PRE_W-1:0]   pre;
  logic [PRE_W-1:0]   pre_nx;
  logic [WIDTH-1:0]   count_nx;
  logic [WIDTH-1:0]   step_val;
  logic [WIDTH-1:0]   term_val;
  logic               pre_last;
  logic               tick_nx;
  logic               done_nx;

  always_comb begin
    state_nx = state;
    count_nx = count;
    pre_nx   = pre;
    tick_nx  = 1'b0;
    done_nx  = 1'b0;
    step_val = dir ? count - WIDTH'(1) : count + WIDTH'(1);
    term_val = {WIDTH{~dir}};
    pre_last = (pre == PRE_W'(DIV - 1));
    case (state)
      IDLE: begin
        pre_nx = '0;
        if (load_en) count_nx = load_val;
        if (start_ev && !stop_ev) state_nx = RUN;
      end
      RUN: begin
        if (tick) begin
          count_nx = step_val;
          if (!wrap_en && step_val == term_val) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end
        end
        // a stop freezes pre, so a rollover due this cycle waits for the resume
        if (stop_ev) begin
          state_nx = PAUSE;
          done_nx  = 1'b0;
        end else if (pre_last) begin
          pre_nx  = '0;
          tick_nx = 1'b1;
        end else begin
          pre_nx = pre + PRE_W'(1);
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          state_nx = IDLE;
          count_nx = '0;
        end else begin
          if (load_en) count_nx = load_val;
          if (start_ev) state_nx = RUN;
        end
      end
      DONE: begin
        pre_nx = '0;
        if (stop_ev) begin
          state_nx = IDLE;
          count_nx = '0;
        end else if (start_ev) begin
          state_nx = RUN;
          count_nx = {WIDTH{dir}};
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      dir     <= 1'b0;
      pre     <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      dir     <= dir ^ dir_ev;
      pre     <= pre_nx;
      tick    <= tick_nx;
      done    <= done_nx;
      running <= (state_nx == RUN);
    end
  end
endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random button traffic, each
// cycle compared against a spec-level model (window debounce, modulo counting).

module tb_counter_ctrl;
  localparam int W = 4;
  localparam int DIV = 10;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_start = 1'b0, btn_stop = 1'b0, btn_dir = 1'b0;
  logic         load_en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         wrap_en = 1'b1;
  logic [W-1:0] count;
  logic         running, dir, tick, done;
  logic [W+3:0] obs;

  always #5 clk = ~clk;

  counter_ctrl #(.CLK_HZ(40), .TICK_HZ(4), .DEBOUNCE_CYCLES(3), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_dir(btn_dir), .load_en(load_en), .load_val(load_val), .wrap_en(wrap_en),
    .count(count), .running(running), .dir(dir), .tick(tick), .done(done)
  );

  assign obs = {count, running, dir, tick, done};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model
  int m_state, m_count, m_pre;
  bit m_dir, m_tick, m_done;
  bit hist [3][5];
  bit lvl [3];
  bit ev [3];

  function automatic void model_reset();
    m_state = S_IDLE; m_count = 0; m_pre = 0;
    m_dir = 1'b0; m_tick = 1'b0; m_done = 1'b0;
    for (int b = 0; b < 3; b++) begin
      lvl[b] = 1'b0; ev[b] = 1'b0;
      for (int k = 0; k < 5; k++) hist[b][k] = 1'b0;
    end
  endfunction

  function automatic logic [W+3:0] exp_vec();
    logic [31:0] c;
    c = 32'(m_count);
    return {c[W-1:0], m_state == S_RUN, m_dir, m_tick, m_done};
  endfunction

  // advance one clock and the model alongside it
  task automatic cyc_step();
    int n_state, n_count, n_pre;
    bit n_tick, n_done;
    bit [2:0] raw;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      n_state = m_state; n_count = m_count; n_pre = m_pre;
      n_tick = 1'b0; n_done = 1'b0;
      case (m_state)
        S_IDLE: begin
          n_pre = 0;
          if (load_en) n_count = int'(load_val);
          if (ev[0] && !ev[1]) n_state = S_RUN;
        end
        S_RUN: begin
          if (m_tick) begin
            n_count = (m_count + (m_dir ? 15 : 1)) % 16;
            if (!wrap_en && n_count == (m_dir ? 0 : 15)) begin n_state = S_DONE; n_done = 1'b1; end
          end
          if (ev[1]) begin
            n_state = S_PAUSE; n_done = 1'b0;
          end else begin
            n_pre = (m_pre + 1) % DIV;
            n_tick = (n_pre == 0);
          end
        end
        S_PAUSE: begin
          if (ev[1]) begin n_state = S_IDLE; n_count = 0; end
          else begin
            if (load_en) n_count = int'(load_val);
            if (ev[0]) n_state = S_RUN;
          end
        end
        default: begin
          n_pre = 0;
          if (ev[1]) begin n_state = S_IDLE; n_count = 0; end
          else if (ev[0]) begin n_state = S_RUN; n_count = m_dir ? 15 : 0; end
        end
      endcase
      m_dir = m_dir ^ ev[2];
      m_state = n_state; m_count = n_count; m_pre = n_pre; m_tick = n_tick; m_done = n_done;
      // debounced level follows three equal samples seen through the two-flop delay
      raw = {btn_dir, btn_stop, btn_start};
      for (int b = 0; b < 3; b++) begin
        for (int k = 4; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = raw[b];
        ev[b] = 1'b0;
        if (hist[b][2] == hist[b][3] && hist[b][3] == hist[b][4] && hist[b][2] != lvl[b]) begin
          lvl[b] = hist[b][2];
          ev[b] = hist[b][2];
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    btn_start = 1'b0; btn_stop = 1'b0; btn_dir = 1'b0; load_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_hold: outputs %h, expected 00", obs); end
    btn_start = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_press: outputs %h, expected 00", obs); end
    btn_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_debounce();
    int run_it = -1, rises = 0;
    logic prev_run = 1'b0;
    do_reset();
    wrap_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      btn_start = (i < 2) || (i >= 8 && i < 28);
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL debounce i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
      if (running === 1'b1 && prev_run === 1'b0) begin rises++; if (run_it < 0) run_it = i; end
      prev_run = running;
    end
    checks++;
    if (run_it != 13 || rises != 1) begin
      errors++; $display("FAIL debounce_latency: running rose at %0d (%0d rises), expected 13 (1 rise)", run_it, rises);
    end
  endtask

  task automatic test_count_wrap();
    int ticks = 0, last_tick = -1, run_it = -1, dones = 0;
    do_reset();
    wrap_en = 1'b1;
    for (int i = 0; i < 180; i++) begin
      btn_start = (i < 4);
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL wrap i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
      if (run_it < 0 && running === 1'b1) run_it = i;
      if (done === 1'b1) dones++;
      if (tick === 1'b1) begin
        checks++;
        if (i - (last_tick < 0 ? run_it : last_tick) != DIV) begin
          errors++; $display("FAIL wrap_period: tick at %0d, previous mark %0d, expected spacing %0d", i, last_tick < 0 ? run_it : last_tick, DIV);
        end
        last_tick = i;
        ticks++;
      end
    end
    checks++;
    if (ticks != 17 || count !== 4'd1 || dones != 0) begin
      errors++; $display("FAIL wrap_total: ticks %0d count %0d dones %0d, expected 17 1 0", ticks, count, dones);
    end
  endtask

  task automatic test_saturate();
    int dones = 0;
    do_reset();
    wrap_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      load_en = (i == 0);
      load_val = 4'd2;
      btn_dir = (i >= 1 && i < 5);
      btn_start = (i >= 12 && i < 16);
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL saturate i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (count !== 4'd0 || i != 38) begin errors++; $display("FAIL saturate_done: count %0d at %0d, expected 0 at 38", count, i); end
      end
    end
    checks++;
    if (dones != 1 || count !== 4'd0 || running !== 1'b0 || dir !== 1'b1) begin
      errors++; $display("FAIL saturate_end: dones %0d count %0d running %b dir %b, expected 1 0 0 1", dones, count, running, dir);
    end
  endtask

  task automatic test_pause_resume();
    int t_stop = -1, run2 = -1, tick2 = -1;
    do_reset();
    wrap_en = 1'b1;
    for (int i = 0; i < 135; i++) begin
      if (t_stop < 0 && i > 20 && m_state == S_RUN && m_pre == 1) t_stop = i;
      btn_start = (i < 4) || (t_stop >= 0 && i >= t_stop + 45 && i < t_stop + 49);
      btn_stop = (t_stop >= 0 && i >= t_stop && i < t_stop + 4) || (i >= 110 && i < 114) || (i >= 122 && i < 126);
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL pause i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
      if (t_stop >= 0 && run2 < 0 && i > t_stop + 10 && running === 1'b1) run2 = i;
      if (run2 >= 0 && tick2 < 0 && tick === 1'b1) tick2 = i;
    end
    checks++;
    if (run2 < 0 || tick2 - run2 != 4) begin
      errors++; $display("FAIL pause_resume: resumed at %0d first tick at %0d, expected tick 4 cycles later", run2, tick2);
    end
    checks++;
    if (count !== 4'd0 || running !== 1'b0) begin
      errors++; $display("FAIL pause_stop2: count %0d running %b, expected 0 0", count, running);
    end
  endtask

  task automatic test_simultaneous();
    int td = -1, c0 = 0;
    do_reset();
    wrap_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (td < 0 && i > 40 && m_state == S_RUN && m_pre == 5) td = i;
      btn_start = (i < 4) || (i >= 18 && i < 22) || (i >= 30 && i < 34);
      btn_stop = (i >= 18 && i < 22);
      btn_dir = (td >= 0 && i >= td && i < td + 4);
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL simul i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
      if (i == 24) begin
        checks++;
        if (running !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL simul_pause: running %b count %0d, expected 0 1", running, count); end
      end
      if (td >= 0 && i == td + 4) begin
        c0 = m_count;
        checks++;
        if (tick !== 1'b1 || dir !== 1'b0) begin errors++; $display("FAIL simul_align: tick %b dir %b, expected 1 0", tick, dir); end
      end
      if (td >= 0 && i == td + 5) begin
        checks++;
        if (count !== 4'((c0 + 1) % 16) || dir !== 1'b1) begin
          errors++; $display("FAIL simul_dir: count %0d dir %b, expected %0d 1", count, dir, (c0 + 1) % 16);
        end
      end
    end
    checks++;
    if (td < 0) begin errors++; $display("FAIL simul_setup: no aligned dir press, expected one"); end
  endtask

  task automatic test_random();
    do_reset();
    wrap_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 39) == 0) btn_stop = ~btn_stop;
      if ($urandom_range(0, 24) == 0) btn_dir = ~btn_dir;
      if ($urandom_range(0, 199) == 0) wrap_en = ~wrap_en;
      load_en = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
    end
    btn_start = 1'b0; btn_stop = 1'b0; btn_dir = 1'b0; load_en = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    int ticks = 0;
    do_reset();
    wrap_en = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      load_en = (i == 0);
      load_val = 4'd6;
      btn_start = (i < 4);
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL areset_run i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
      if (m_state == S_RUN && m_count == 7 && m_pre == 5) found = 1'b1;
    end
    load_en = 1'b0; btn_start = 1'b0;
    checks++;
    if (!found) begin errors++; $display("FAIL areset_reach: count 7 pre 5 not reached, expected within 200 cycles"); end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL areset_async: outputs %h, expected 00", obs); end
    model_reset();
    repeat (2) cyc_step();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc_step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL areset_after i=%0d: outputs %h, expected %h", i, obs, exp_vec()); end
      if (tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 0 || running !== 1'b0) begin errors++; $display("FAIL areset_quiet: ticks %0d running %b, expected 0 0", ticks, running); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_debounce();
    test_count_wrap();
    test_saturate();
    test_pause_resume();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Synchronous run/pause/direction controller for the 4-bit LED counter on the iCEstick (12 MHz).
- Takes three raw PMOD push-buttons, synchronises and debounces them, and generates a one-cycle tick enable from a prescaler. No derived clocks.
- Sequences the counter through idle, run, pause and terminal states, with direction control, parallel load and wrap/saturate selection.
- All state lives in the `clk` domain.

## Interface
- `CLK_HZ`, 12000000: input clock frequency.
- `TICK_HZ`, 1: count rate. `DIV = CLK_HZ/TICK_HZ`, which must be ≥ 2 and an integer.
- `DEBOUNCE_CYCLES`, 120000: cycles a synchronised button must be stable before its debounced level changes (10 ms).
- `WIDTH`, 4: counter width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `btn_start`  in  1  raw asynchronous button, active-high.
- `btn_stop`  in  1  raw asynchronous button, active-high.
- `btn_dir`  in  1  raw asynchronous button, active-high.
- `load_en`  in  1  synchronous level; load request.
- `load_val`  in  WIDTH  value to load.
- `wrap_en`  in  1  synchronous level; 1 = wrap at terminal, 0 = stop at terminal.
- `count`  out  WIDTH  counter value; drives the LEDs.
- `running`  out  1  high while in RUN.
- `dir`  out  1  0 = up, 1 = down.
- `tick`  out  1  one-cycle pulse at each prescaler rollover while in RUN.
- `done`  out  1  one-cycle pulse on entry to DONE.

## Operation
**Button path** (identical for each button):
- Two-flop synchroniser, then a stability counter.
- The debounced level updates only after `DEBOUNCE_CYCLES` consecutive equal synchronised samples that differ from the current level.
- A rising edge of the debounced level produces a one-cycle press event. Release produces no event.
- One event per physical press, regardless of hold time.

**Prescaler:**
- `pre` counts 0..DIV-1, width `$clog2(DIV)`, and increments only in RUN.
- When `pre == DIV-1` in RUN: `pre` goes to 0 and `tick` pulses.
- `pre` is cleared on entry to RUN from IDLE or DONE, held in PAUSE, and cleared in IDLE.

**State machine** (IDLE, RUN, PAUSE, DONE):
- **IDLE:** `count` held.
  - start → RUN; `pre` cleared.
  - `load_en` → `count` = `load_val`.
- **RUN:** on `tick`, `count` ± 1 per `dir`.
  - stop → PAUSE.
  - If `wrap_en` = 0 and the tick moves `count` onto terminal (all-ones when up, 0 when down): enter DONE and pulse `done`.
  - If `wrap_en` = 1: modulo-2^WIDTH wrap; DONE is never entered.
- **PAUSE:** `count` and `pre` held.
  - start → RUN, resuming the partial prescale.
  - stop → IDLE with `count` = 0.
  - `load_en` → `count` = `load_val`.
- **DONE:** `count` held at terminal.
  - start → RUN with `count` = 0 (up) or all-ones (down); `pre` cleared.
  - stop → IDLE with `count` = 0.

**Direction and outputs:**
- A dir event toggles `dir` in any state.
- `running` = (state == RUN).

**Conflicts:**
- start and stop events in the same cycle: stop wins; start is discarded.
- tick and stop in the same cycle in RUN: the count step is applied, then PAUSE.
- dir event and tick in the same cycle: the step uses the old `dir`.
- `load_en` is ignored in RUN and DONE.
- In RUN with `wrap_en` = 0, an already-terminal `count` (for example, loaded) steps normally; DONE is entered only when a tick lands on terminal.

**Reset:**
- Asynchronous, from any state including mid-debounce or mid-prescale.
- state = IDLE, `count` = 0, `dir` = 0, `pre` = 0, `tick` = 0, `done` = 0, `running` = 0.
- Synchroniser flops, debounce counters and debounced levels = 0.

## Timing
- Button latency: press event is high 2 + `DEBOUNCE_CYCLES` cycles after a clean input edge, for exactly 1 cycle. The state and `running` change on the next clock edge.
- `count` updates on the clock edge after `tick` is high.
- The `done` pulse coincides with the cycle `count` first shows terminal.
- Tick period in RUN is exactly `DIV` cycles. First tick after start from IDLE occurs `DIV` cycles after entering RUN.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
Bench parameters: `CLK_HZ` = 40, `TICK_HZ` = 4 (`DIV` = 10), `DEBOUNCE_CYCLES` = 3.
1. **Debounce:** pulse `btn_start` for 2 cycles, then hold for 20 cycles → exactly one start event, 5 cycles after the stable edge; `running` = 1 one cycle later.
2. **Count and wrap:** start with `wrap_en` = 1, run 170 cycles → ticks every 10 cycles, `count` goes 0→15→0→1; no `done`.
3. **Saturate down:** load 2 in IDLE, toggle `dir` to down, start with `wrap_en` = 0 → `count` 1, 0; `done` pulses once; state DONE; `count` stays 0 for 50 more cycles.
4. **Pause/resume:** stop when `pre` = 6, wait 40 cycles, start → first tick 4 cycles after resume; stop twice from RUN → IDLE, `count` = 0.
5. **Simultaneous events:** start and stop events in the same cycle while in RUN → PAUSE. A dir event coincident with a tick → that step uses the old direction.
6. **Reset:** assert `reset` mid-RUN at `count` = 7 with `pre` = 5 → all outputs 0 immediately (asynchronous); after release, `tick` stays low until a new start.
